wb_stage_pipe: RTL and testbench
================================

// Module: wb_stage_pipe
// PURPOSE
// - Parametrised MEM->WB pipeline register with valid/ready handshake, stall hold and flush.
// - Carries pc, instr, alu result, load/store result, csr data and wb enable into write-back.
// - Inserts bubbles when upstream is empty; holds contents while WB is stalled.
// - Optional 1-entry skid buffer registers in_ready, cutting the combinational ready path.
// PARAMETERS
// - XLEN    64  datapath width of pc/alures/lsres/csrdata
// - INST_W  32  instruction width
// PORTS
// - clk          in   1       clock, rising edge
// - rst_n        in   1       reset, asynchronous, active-low
// - flush_i      in   1       sync flush: kill held and incoming entries
// - in_valid_i   in   1       upstream entry valid
// - in_ready_o   out  1       stage can accept this cycle
// - pc_i/alures_i/lsres_i/csrdata_i  in  XLEN  payload in
// - instr_i      in   INST_W  payload in
// - wben_i       in   1       regfile write enable in
// - out_valid_o  out  1       WB entry valid
// - out_ready_i  in   1       WB consumes entry this cycle
// - pc_o/alures_o/lsres_o/csrdata_o  out XLEN  registered payload
// - instr_o      out  INST_W  registered payload
// - wben_o       out  1       = held wben AND out_valid_o (never asserted on a bubble)
// BEHAVIOUR
// - Reset: out_valid_o=0, all payload outputs 0, wben_o=0, skid empty; in_ready_o=1 after reset.
// - Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
// - Latency: entry accepted in cycle N appears on outputs in cycle N+1.
// - Base (no skid): in_ready_o = ~out_valid_o | out_ready_i (combinational).
//   - on in-transfer: payload regs load, out_valid_o<=1.
//   - out-transfer without in-transfer: out_valid_o<=0 (bubble); payload regs hold stale value.
//   - stall (out_valid_o & ~out_ready_i): all regs hold, in_ready_o=0.
// - Payload regs load only on in-transfer (clock-enable); never load when in_valid_i=0.
// - flush_i (priority over everything): next cycle out_valid_o=0, skid empty, wben_o=0;
//   entry presented same cycle is discarded even if in_valid_i=1; in_ready_o unaffected.
// - Reset asserted mid-stall: all state cleared asynchronously; no entry survives.
// - Simultaneous in- and out-transfer: new entry replaces old, out_valid_o stays 1 (full throughput).
// CONFIGURATION
// - WB_SKID_BUF_EN defined:
//   - in_ready_o = registered ~skid_valid; no comb path from out_ready_i to in_ready_o.
//   - in-transfer while main full and ~out_ready_i: entry written to skid, skid_valid<=1.
//   - out_ready_i with skid full: skid moves to main next cycle, skid_valid<=0.
//   - ordering strictly FIFO; capacity 2 entries; still 1-cycle latency when unstalled.
//   - flush clears main and skid together.
// - Undefined: skid logic absent; base combinational in_ready_o as above.
// TESTING
// - Stream: in_valid=1, out_ready=1, pc=0x1000,0x1004,0x1008 -> out pc same order, 1-cycle lag, no gaps.
// - Bubble: in_valid=1 one cycle (pc=0x2000,wben=1) then 0 -> out_valid 1 cycle, then 0, wben_o=0.
// - Stall: out_ready=0 for 3 cycles with out pc=0x3000 -> outputs hold 0x3000, in_ready=0 (base);
//   skid build: second entry 0x3004 captured, in_ready drops next cycle, release yields 0x3000,0x3004.
// - Flush: held entry 0x4000 + incoming 0x4004 with flush_i=1 -> next cycle out_valid=0, wben_o=0,
//   neither entry ever appears.
// - Reset mid-stall: rst_n low while out_valid=1 -> out_valid=0, all payloads 0 immediately.
// - Scoreboard: random in_valid/out_ready/flush 10k cycles -> no loss, duplication or reorder.

Source files
------------

// File: rtl/wb_stage_pipe_if.sv
// MEM->WB stage handshake and payload bundle; slave is the pipeline stage, master drives it.
interface wb_stage_pipe_if #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned INST_W = 32
);
   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [XLEN-1:0]   pc_i;
   logic [INST_W-1:0] instr_i;
   logic [XLEN-1:0]   alures_i;
   logic [XLEN-1:0]   lsres_i;
   logic [XLEN-1:0]   csrdata_i;
   logic              wben_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [XLEN-1:0]   pc_o;
   logic [INST_W-1:0] instr_o;
   logic [XLEN-1:0]   alures_o;
   logic [XLEN-1:0]   lsres_o;
   logic [XLEN-1:0]   csrdata_o;
   logic              wben_o;

   modport slave (
      input  flush_i, in_valid_i, pc_i, instr_i, alures_i, lsres_i, csrdata_i, wben_i, out_ready_i,
      output in_ready_o, out_valid_o, pc_o, instr_o, alures_o, lsres_o, csrdata_o, wben_o
   );

   modport master (
      output flush_i, in_valid_i, pc_i, instr_i, alures_i, lsres_i, csrdata_i, wben_i, out_ready_i,
      input  in_ready_o, out_valid_o, pc_o, instr_o, alures_o, lsres_o, csrdata_o, wben_o
   );
endinterface

// File: rtl/wb_stage_pipe.sv
// MEM->WB pipeline register with valid/ready handshake, stall hold and flush.
// Define WB_SKID_BUF_EN to add a 1-entry skid buffer that registers in_ready_o.
module wb_stage_pipe #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned INST_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_stage_pipe_if.slave  bus
);
   localparam int unsigned PW = 4 * XLEN + INST_W + 1;

   logic [PW-1:0] in_pl;
   logic [PW-1:0] main_q, main_d;
   logic          main_v_q, main_v_d;
   logic          wben_q;
   logic          in_xfer;
   logic          out_xfer;

   assign in_pl    = {bus.pc_i, bus.instr_i, bus.alures_i, bus.lsres_i, bus.csrdata_i, bus.wben_i};
   assign in_xfer  = bus.in_valid_i & bus.in_ready_o;
   assign out_xfer = main_v_q & bus.out_ready_i;

   assign {bus.pc_o, bus.instr_o, bus.alures_o, bus.lsres_o, bus.csrdata_o, wben_q} = main_q;
   assign bus.out_valid_o = main_v_q;
   assign bus.wben_o      = wben_q & main_v_q;

`ifdef WB_SKID_BUF_EN
   logic [PW-1:0] skid_q, skid_d;
   logic          skid_v_q, skid_v_d;

   // Ready depends only on skid occupancy, so out_ready_i never reaches in_ready_o combinationally.
   assign bus.in_ready_o = ~skid_v_q;

   always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (bus.flush_i) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (skid_v_q) begin
         // Skid full implies main full; drain skid into main when WB consumes the head.
         if (bus.out_ready_i) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
         end
      end else if (in_xfer) begin
         if (main_v_q && !bus.out_ready_i) begin
            skid_d   = in_pl;
            skid_v_d = 1'b1;
         end else begin
            main_d   = in_pl;
            main_v_d = 1'b1;
         end
      end else if (out_xfer) begin
         main_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q   <= '0;
         skid_v_q <= 1'b0;
      end else begin
         skid_q   <= skid_d;
         skid_v_q <= skid_v_d;
      end
   end
`else
   assign bus.in_ready_o = ~main_v_q | bus.out_ready_i;

   always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      if (bus.flush_i) begin
         main_v_d = 1'b0;
      end else if (in_xfer) begin
         main_d   = in_pl;
         main_v_d = 1'b1;
      end else if (out_xfer) begin
         main_v_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q   <= '0;
         main_v_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         main_v_q <= main_v_d;
      end
   end
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe against a queue-based occupancy model (base or WB_SKID_BUF_EN).
module tb_wb_stage_pipe;
   localparam int unsigned XLEN   = 64;
   localparam int unsigned INST_W = 32;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] instr;
      logic [XLEN-1:0]   alures;
      logic [XLEN-1:0]   lsres;
      logic [XLEN-1:0]   csrdata;
      logic              wben;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   ent_t q[$];

   wb_stage_pipe_if #(.XLEN(XLEN), .INST_W(INST_W)) bus ();

   wb_stage_pipe #(.XLEN(XLEN), .INST_W(INST_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic ent_t mk_ent(input logic [XLEN-1:0] pc, input logic wben);
      ent_t e;
      e.pc      = pc;
      e.instr   = INST_W'($urandom);
      e.alures  = {32'($urandom), 32'($urandom)};
      e.lsres   = {32'($urandom), 32'($urandom)};
      e.csrdata = {32'($urandom), 32'($urandom)};
      e.wben    = wben;
      return e;
   endfunction

   // Stage capacity: one entry in the base build, two with the skid buffer.
   function automatic logic mdl_ready();
`ifdef WB_SKID_BUF_EN
      return logic'(q.size() < 2);
`else
      return logic'(q.size() == 0) | bus.out_ready_i;
`endif
   endfunction

   function automatic ent_t obs_ent();
      ent_t e;
      e = '{bus.pc_o, bus.instr_o, bus.alures_o, bus.lsres_o, bus.csrdata_o, bus.wben_o};
      return e;
   endfunction

   task automatic drive(input logic v, input ent_t e, input logic ordy, input logic fl);
      bus.in_valid_i  = v;
      bus.pc_i        = e.pc;
      bus.instr_i     = e.instr;
      bus.alures_i    = e.alures;
      bus.lsres_i     = e.lsres;
      bus.csrdata_i   = e.csrdata;
      bus.wben_i      = e.wben;
      bus.out_ready_i = ordy;
      bus.flush_i     = fl;
      #1;
   endtask

   // Advance one clock and update the model queue from the handshake rules.
   task automatic tick();
      ent_t cur;
      logic in_x, out_x, fl;
      cur   = '{bus.pc_i, bus.instr_i, bus.alures_i, bus.lsres_i, bus.csrdata_i, bus.wben_i};
      in_x  = bus.in_valid_i & mdl_ready();
      out_x = logic'(q.size() > 0) & bus.out_ready_i;
      fl    = bus.flush_i;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (out_x) void'(q.pop_front());
         if (in_x) q.push_back(cur);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, mk_ent(64'h0, 1'b0), 1'b0, 1'b0);
      q.delete();
      #20;
      total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid_o); end
      total++; if (obs_ent() !== ent_t'(0)) begin bad++; $display("FAIL reset_payload got=%h exp=0", obs_ent()); end
      total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready_o); end
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk_ent(64'h1000 + 64'(4 * i), 1'b1), 1'b1, 1'b0);
         total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, bus.in_ready_o); end
         tick();
         total++; if (bus.out_valid_o !== 1'b1 || bus.pc_o !== 64'h1000 + 64'(4 * i) || obs_ent() !== q[0])
            begin bad++; $display("FAIL stream_out[%0d] got=%b/%h exp=1/%h", i, bus.out_valid_o, bus.pc_o, 64'h1000 + 64'(4 * i)); end
      end
      drive(1'b0, mk_ent(64'h0, 1'b0), 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_bubble();
      drive(1'b1, mk_ent(64'h2000, 1'b1), 1'b1, 1'b0);
      tick();
      total++; if (bus.out_valid_o !== 1'b1 || bus.wben_o !== 1'b1 || bus.pc_o !== 64'h2000)
         begin bad++; $display("FAIL bubble_first got=%b/%b/%h exp=1/1/2000", bus.out_valid_o, bus.wben_o, bus.pc_o); end
      drive(1'b0, mk_ent(64'h2004, 1'b1), 1'b1, 1'b0);
      tick();
      total++; if (bus.out_valid_o !== 1'b0 || bus.wben_o !== 1'b0)
         begin bad++; $display("FAIL bubble_empty got=%b/%b exp=0/0", bus.out_valid_o, bus.wben_o); end
   endtask

   task automatic test_stall();
      logic exp_rdy;
      drive(1'b1, mk_ent(64'h3000, 1'b1), 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(logic'(q.size() < 2), mk_ent(64'h3004, 1'b1), 1'b0, 1'b0);
`ifdef WB_SKID_BUF_EN
         exp_rdy = logic'(i == 0);
`else
         exp_rdy = 1'b0;
`endif
         total++; if (bus.in_ready_o !== exp_rdy) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=%b", i, bus.in_ready_o, exp_rdy); end
         tick();
         total++; if (bus.out_valid_o !== 1'b1 || bus.pc_o !== 64'h3000)
            begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/3000", i, bus.out_valid_o, bus.pc_o); end
      end
      // Base build takes 0x3004 on release; the skid build already holds it.
      drive(logic'(q.size() < 2), mk_ent(64'h3004, 1'b1), 1'b1, 1'b0);
      tick();
      total++; if (bus.out_valid_o !== 1'b1 || bus.pc_o !== 64'h3004)
         begin bad++; $display("FAIL stall_release got=%b/%h exp=1/3004", bus.out_valid_o, bus.pc_o); end
      drive(1'b0, mk_ent(64'h0, 1'b0), 1'b1, 1'b0);
      tick();
      total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", bus.out_valid_o); end
   endtask

   task automatic test_flush();
      drive(1'b1, mk_ent(64'h4000, 1'b1), 1'b0, 1'b0);
      tick();
      drive(1'b1, mk_ent(64'h4004, 1'b1), 1'b0, 1'b1);
      tick();
      total++; if (bus.out_valid_o !== 1'b0 || bus.wben_o !== 1'b0)
         begin bad++; $display("FAIL flush_kill got=%b/%b exp=0/0", bus.out_valid_o, bus.wben_o); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, mk_ent(64'h0, 1'b0), 1'b1, 1'b0);
         tick();
         total++; if (bus.out_valid_o !== 1'b0)
            begin bad++; $display("FAIL flush_ghost[%0d] got=%b/%h exp=0", i, bus.out_valid_o, bus.pc_o); end
      end
   endtask

   task automatic test_reset_stall();
      drive(1'b1, mk_ent(64'h5000, 1'b1), 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      q.delete();
      #1;
      total++; if (bus.out_valid_o !== 1'b0 || obs_ent() !== ent_t'(0))
         begin bad++; $display("FAIL rst_stall got=%b/%h exp=0/0", bus.out_valid_o, obs_ent()); end
      total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_stall_ready got=%b exp=1", bus.in_ready_o); end
      drive(1'b0, mk_ent(64'h0, 1'b0), 1'b0, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_stall_after got=%b exp=0", bus.out_valid_o); end
   endtask

   task automatic test_random();
      logic [XLEN-1:0] pc = 64'h10000;
      for (int c = 0; c < 10000; c++) begin
         drive(logic'($urandom_range(0, 9) < 7), mk_ent(pc, 1'($urandom)),
               logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 49) == 0));
         pc = pc + 64'd4;
         total++; if (bus.out_valid_o !== logic'(q.size() > 0))
            begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid_o, q.size() > 0); end
         total++; if (bus.in_ready_o !== mdl_ready())
            begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.in_ready_o, mdl_ready()); end
         if (q.size() > 0) begin
            total++; if (obs_ent() !== q[0])
               begin bad++; $display("FAIL rnd_payload c=%0d got=%h exp=%h", c, obs_ent(), q[0]); end
         end else begin
            total++; if (bus.wben_o !== 1'b0)
               begin bad++; $display("FAIL rnd_wben_bubble c=%0d got=%b exp=0", c, bus.wben_o); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_bubble();
      test_stall();
      test_flush();
      test_reset_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
